alu_mac_seq: RTL

- Multi-cycle sequencer for the custom MAC instruction: computes rd = rs1*rs2 + acc by iterative shift-and-add, reusing the shared integer ALU adder instead of a dedicated multiplier.
- Sits beside the IEU ALU in the Execute stage.
- Arbitrates the ALU against normal IEU traffic (IEU always wins).
- Valid/ready handshakes on both the operand side and the result side.

---
 rtl/alu_mac_seq_pkg.sv | 13 +
 rtl/mac_opregs.sv | 56 +++++
 rtl/alu_mac_seq.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/alu_mac_seq_pkg.sv
// Shared types and constants for the MAC shift-and-add sequencer.
// MAC_EARLY_TERM_EN (optional) is consumed by alu_mac_seq, not here.
package alu_mac_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } mac_state_t;

    localparam logic [2:0] MAC_ALUSEL_ADD = 3'b000;

endpackage

// File: rtl/mac_opregs.sv
// Datapath registers of the MAC sequencer: partial sum P, shifted multiplicand M,
// shifted multiplier Q, step counter and the latched word-op flag.
module mac_opregs
    import alu_mac_seq_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int LOG_XLEN = 6
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                load,
    input  logic                step,
    input  logic                use_sum,
    input  logic                w64_in,
    input  logic [XLEN-1:0]     acc_in,
    input  logic [XLEN-1:0]     rs1_in,
    input  logic [XLEN-1:0]     rs2_in,
    input  logic [XLEN-1:0]     sum_in,
    output logic [XLEN-1:0]     p,
    output logic [XLEN-1:0]     m,
    output logic [XLEN-1:0]     q,
    output logic [LOG_XLEN:0]   cnt,
    output logic                w64
);

    localparam logic [XLEN-1:0] LO32_MASK = XLEN'({32{1'b1}});

    logic [XLEN-1:0] op_mask;

    // Word ops zero-extend the low halves; the final sign extension fixes the result.
    assign op_mask = w64_in ? LO32_MASK : '1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            p   <= '0;
            m   <= '0;
            q   <= '0;
            cnt <= '0;
            w64 <= 1'b0;
        end else if (load) begin
            p   <= acc_in & op_mask;
            m   <= rs1_in & op_mask;
            q   <= rs2_in & op_mask;
            cnt <= '0;
            w64 <= w64_in;
        end else if (step) begin
            if (use_sum) begin
                p <= sum_in;
            end
            m   <= m << 1;
            q   <= q >> 1;
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_mac_seq.sv
// Multi-cycle rd = rs1*rs2 + acc sequencer borrowing the shared ALU adder; IEU has priority.
// Optional macro MAC_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are zero.
module alu_mac_seq
    import alu_mac_seq_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int LOG_XLEN = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             MacValid,
    output logic             MacReady,
    input  logic [XLEN-1:0]  Rs1,
    input  logic [XLEN-1:0]  Rs2,
    input  logic [XLEN-1:0]  Acc,
    input  logic             W64,
    input  logic             Flush,
    input  logic             IEUALUReq,
    output logic             ALUOwn,
    output logic [XLEN-1:0]  ALUA,
    output logic [XLEN-1:0]  ALUB,
    output logic             ALUSubArith,
    output logic [2:0]       ALUSelect,
    input  logic [XLEN-1:0]  ALUSum,
    output logic             ResValid,
    input  logic             ResReady,
    output logic [XLEN-1:0]  Res,
    output logic             Busy
);

    localparam int CW = LOG_XLEN + 1;

    mac_state_t      state, state_next;
    logic [XLEN-1:0] p, m, q, res_full;
    logic [CW-1:0]   cnt;
    logic            w64_reg, w64_eff;
    logic            accept, need_alu, stall, step, last_step, q_done;

    assign w64_eff  = (XLEN == 64) && W64;
    assign accept   = (state == IDLE) && MacValid && !Flush;
    assign need_alu = (state == ITER) && q[0];
    assign stall    = need_alu && IEUALUReq;
    assign step     = (state == ITER) && !stall && !Flush;

    assign last_step = (cnt == (w64_reg ? CW'(31) : CW'(XLEN - 1)));

`ifdef MAC_EARLY_TERM_EN
    assign q_done = (q[XLEN-1:1] == '0);
`else
    assign q_done = 1'b0;
`endif

    mac_opregs #(
        .XLEN     (XLEN),
        .LOG_XLEN (LOG_XLEN)
    ) u_opregs (
        .clk     (clk),
        .resetn  (resetn),
        .load    (accept),
        .step    (step),
        .use_sum (q[0]),
        .w64_in  (w64_eff),
        .acc_in  (Acc),
        .rs1_in  (Rs1),
        .rs2_in  (Rs2),
        .sum_in  (ALUSum),
        .p       (p),
        .m       (m),
        .q       (q),
        .cnt     (cnt),
        .w64     (w64_reg)
    );

    // Upper bits of P carry junk from the zero-extended word multiply; drop them here.
    if (XLEN == 64) begin : g_res64
        assign res_full = w64_reg ? {{32{p[31]}}, p[31:0]} : p;
    end else begin : g_res32
        assign res_full = p;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = ITER;
                end
            end
            ITER: begin
                if (Flush) begin
                    state_next = IDLE;
                end else if (step && (last_step || q_done)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (Flush || ResReady) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        MacReady    = 1'b0;
        ALUOwn      = 1'b0;
        ALUA        = '0;
        ALUB        = '0;
        ResValid    = 1'b0;
        Res         = '0;
        Busy        = 1'b1;
        ALUSubArith = 1'b0;
        ALUSelect   = MAC_ALUSEL_ADD;
        case (state)
            IDLE: begin
                MacReady = !Flush;
                Busy     = 1'b0;
            end
            ITER: begin
                if (need_alu && !IEUALUReq) begin
                    ALUOwn = 1'b1;
                    ALUA   = p;
                    ALUB   = m;
                end
            end
            DONE: begin
                ResValid = 1'b1;
                Res      = res_full;
            end
            default: Busy = 1'b0;
        endcase
    end

endmodule
